// File: rtl/track_mode_if.sv
// track_mode_if: mode bus from the line-tracking sequencer (master) to the motor drive block (slave).
interface track_mode_if #(parameter int ROUTE_LEN = 8);
   logic [4:0]                     mode;
   logic [$clog2(ROUTE_LEN+1)-1:0] junction_cnt;
   logic                           fault;
   modport master (output mode, junction_cnt, fault);
   modport slave  (input  mode, junction_cnt, fault);
endinterface

// File: rtl/track_mode_sequencer.sv
// track_mode_sequencer: line-tracking supervisor FSM driving the motor mode code; SENSOR_DEBOUNCE_EN adds sensor debounce.
module track_mode_sequencer #(
   parameter int START_CYCLES    = 100000000,
   parameter int TURN_MIN_CYCLES = 30000000,
   parameter int TURN_TIMEOUT    = 200000000,
   parameter int LOST_CYCLES     = 50000000,
   parameter int ROUTE_LEN       = 8,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [2:0]             sensor,
   input  logic [2*ROUTE_LEN-1:0] route,
   track_mode_if.master           mif
);
   // One counter width serves the COUNT/TURN/lost counter and the debounce counter.
   localparam int M1 = (START_CYCLES > TURN_TIMEOUT) ? START_CYCLES : TURN_TIMEOUT;
   localparam int M2 = (LOST_CYCLES > DEBOUNCE_CYCLES) ? LOST_CYCLES : DEBOUNCE_CYCLES;
   localparam int CW = $clog2((M1 > M2) ? M1 : M2);
   localparam int JW = $clog2(ROUTE_LEN + 1);

   typedef enum logic [4:0] {
      IDLE          = 5'd0,
      START         = 5'd1,
      COUNT         = 5'd2,
      STRAIGHT      = 5'd3,
      CHOOSE        = 5'd4,
      TURN_STRAIGHT = 5'd5,
      TURN_LEFT     = 5'd6,
      TURN_RIGHT    = 5'd7,
      STOP          = 5'd30,
      ERROR         = 5'd31
   } mode_t;

   mode_t          r_mode;
   mode_t          w_pick;
   logic [CW-1:0]  r_cnt;
   logic [CW-1:0]  w_inc;
   logic [JW-1:0]  r_jcnt;
   logic           r_fault;
   logic [2:0]     r_sync1;
   logic [2:0]     r_sync2;
   logic [2:0]     w_s;
   logic [1:0]     w_entry;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= sensor;
         r_sync2 <= r_sync1;
      end
   end

`ifdef SENSOR_DEBOUNCE_EN
   logic [2:0]    r_cand;
   logic [2:0]    r_s;
   logic [CW-1:0] r_db;

   // s follows the synchronized value only once it has stayed unchanged for the full window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cand <= '0;
         r_s    <= '0;
         r_db   <= '0;
      end else if (r_sync2 != r_cand) begin
         r_cand <= r_sync2;
         r_db   <= '0;
      end else if (r_db == CW'(DEBOUNCE_CYCLES - 1)) begin
         r_s <= r_cand;
      end else begin
         r_db <= r_db + CW'(1);
      end
   end

   assign w_s = r_s;
`else
   assign w_s = r_sync2;
`endif

   assign w_inc   = (&r_cnt) ? r_cnt : r_cnt + CW'(1);
   assign w_entry = 2'(route >> {r_jcnt, 1'b0});
   assign w_pick  = (r_jcnt == JW'(ROUTE_LEN) || w_entry == 2'b11) ? STOP
                  : mode_t'(5'd5 + {3'b000, w_entry});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mode  <= IDLE;
         r_cnt   <= '0;
         r_jcnt  <= '0;
         r_fault <= 1'b0;
      end else begin
         r_fault <= 1'b0;
         case (r_mode)
            IDLE: if (start) begin
               r_mode <= START;
               r_jcnt <= '0;
            end
            START: begin
               r_mode <= COUNT;
               r_cnt  <= '0;
            end
            COUNT: if (r_cnt == CW'(START_CYCLES - 1)) begin
               r_mode <= STRAIGHT;
               r_cnt  <= '0;
            end else r_cnt <= w_inc;
            STRAIGHT: if (w_s == 3'b111) begin
               r_mode <= CHOOSE;
               r_cnt  <= '0;
            end else if (w_s != 3'b000) r_cnt <= '0;
            else if (r_cnt == CW'(LOST_CYCLES - 1)) begin
               r_mode  <= ERROR;
               r_fault <= 1'b1;
            end else r_cnt <= w_inc;
            CHOOSE: begin
               r_mode <= w_pick;
               r_cnt  <= '0;
               if (r_jcnt != JW'(ROUTE_LEN)) r_jcnt <= r_jcnt + JW'(1);
            end
            // Realignment is checked before the timeout so it wins a tie.
            TURN_STRAIGHT, TURN_LEFT, TURN_RIGHT:
               if (w_s == 3'b010 && r_cnt >= CW'(TURN_MIN_CYCLES - 1)) begin
                  r_mode <= STRAIGHT;
                  r_cnt  <= '0;
               end else if (r_cnt == CW'(TURN_TIMEOUT - 1)) begin
                  r_mode  <= ERROR;
                  r_fault <= 1'b1;
               end else r_cnt <= w_inc;
            STOP: if (start) r_mode <= IDLE;
            ERROR: if (start) r_mode <= IDLE; else r_fault <= 1'b1;
            default: r_mode <= IDLE;
         endcase
      end
   end

   assign mif.mode         = r_mode;
   assign mif.junction_cnt = r_jcnt;
   assign mif.fault        = r_fault;
endmodule

// File: tb/tb_track_mode_sequencer.sv
// tb_track_mode_sequencer: directed checks of the mode sequencer with short cycle parameters.
module tb_track_mode_sequencer;
   localparam int RL = 2;
   logic          clk    = 1'b0;
   logic          rst_n  = 1'b1;
   logic          start  = 1'b0;
   logic [2:0]    sensor = 3'b000;
   logic [2*RL-1:0] route = '0;
   int n_cmp = 0;
   int n_err = 0;

   track_mode_if #(.ROUTE_LEN(RL)) mif ();

   track_mode_sequencer #(
      .START_CYCLES(10), .TURN_MIN_CYCLES(4), .TURN_TIMEOUT(20),
      .LOST_CYCLES(6), .ROUTE_LEN(RL), .DEBOUNCE_CYCLES(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .sensor(sensor), .route(route), .mif(mif)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset;
      rst_n = 1'b0; start = 1'b0; sensor = 3'b010; route = '0;
      tick(2);
      rst_n = 1'b1;
      tick(1);
   endtask

   task automatic go_straight;
      do_reset;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      n_cmp++; if (mif.mode !== 5'd1) begin n_err++; $display("FAIL start_state: got %0d expected 1", mif.mode); end
      tick(1);
      n_cmp++; if (mif.mode !== 5'd2) begin n_err++; $display("FAIL count_enter: got %0d expected 2", mif.mode); end
      for (int i = 1; i < 10; i++) begin
         tick(1);
         n_cmp++; if (mif.mode !== 5'd2) begin n_err++; $display("FAIL count_hold[%0d]: got %0d expected 2", i, mif.mode); end
      end
      tick(1);
      n_cmp++; if (mif.mode !== 5'd3) begin n_err++; $display("FAIL count_done: got %0d expected 3", mif.mode); end
      n_cmp++; if (mif.junction_cnt !== 2'd0) begin n_err++; $display("FAIL count_jcnt: got %0d expected 0", mif.junction_cnt); end
   endtask

   task automatic junction(input logic [4:0] exp_m, input logic [1:0] exp_j);
      sensor = 3'b111;
      tick(2);
      n_cmp++; if (mif.mode !== 5'd3) begin n_err++; $display("FAIL junc_latency: got %0d expected 3", mif.mode); end
      tick(1);
      n_cmp++; if (mif.mode !== 5'd4) begin n_err++; $display("FAIL choose: got %0d expected 4", mif.mode); end
      sensor = 3'b010;
      tick(1);
      n_cmp++; if (mif.mode !== exp_m) begin n_err++; $display("FAIL junc_mode: got %0d expected %0d", mif.mode, exp_m); end
      n_cmp++; if (mif.junction_cnt !== exp_j) begin n_err++; $display("FAIL junc_cnt: got %0d expected %0d", mif.junction_cnt, exp_j); end
      if (exp_m != 5'd30) begin
         tick(3);
         n_cmp++; if (mif.mode !== exp_m) begin n_err++; $display("FAIL turn_min_hold: got %0d expected %0d", mif.mode, exp_m); end
         tick(1);
         n_cmp++; if (mif.mode !== 5'd3) begin n_err++; $display("FAIL realign: got %0d expected 3", mif.mode); end
      end
   endtask

   task automatic test_reset;
      start = 1'b0; sensor = 3'b000; route = '0;
      #3 rst_n = 1'b0;
      #1;
      n_cmp++; if (mif.mode !== 5'd0) begin n_err++; $display("FAIL reset_mode: got %0d expected 0", mif.mode); end
      n_cmp++; if (mif.junction_cnt !== 2'd0) begin n_err++; $display("FAIL reset_jcnt: got %0d expected 0", mif.junction_cnt); end
      n_cmp++; if (mif.fault !== 1'b0) begin n_err++; $display("FAIL reset_fault: got %0d expected 0", mif.fault); end
      tick(2);
      rst_n = 1'b1;
      tick(3);
      n_cmp++; if (mif.mode !== 5'd0) begin n_err++; $display("FAIL idle_hold: got %0d expected 0", mif.mode); end
   endtask

`ifdef SENSOR_DEBOUNCE_EN
   task automatic test_debounce;
      bit bad = 1'b0;
      bit seen = 1'b0;
      go_straight;
      route = 4'b0101;
      sensor = 3'b111;
      tick(3);
      sensor = 3'b010;
      for (int i = 0; i < 12; i++) begin
         tick(1);
         if (mif.mode !== 5'd3) bad = 1'b1;
      end
      n_cmp++; if (bad) begin n_err++; $display("FAIL glitch_ignored: got mode %0d expected 3 throughout", mif.mode); end
      sensor = 3'b111;
      tick(5);
      sensor = 3'b010;
      for (int i = 0; i < 12; i++) begin
         tick(1);
         if (mif.mode === 5'd4) seen = 1'b1;
      end
      n_cmp++; if (!seen) begin n_err++; $display("FAIL pulse_choose: got no CHOOSE expected mode 4 within 12 cycles"); end
   endtask
`else
   task automatic test_turn_left;
      go_straight;
      route = 4'b0101;
      junction(5'd6, 2'd1);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      n_cmp++; if (mif.mode !== 5'd3) begin n_err++; $display("FAIL start_ignored: got %0d expected 3", mif.mode); end
   endtask

   task automatic test_two_junctions;
      go_straight;
      route = 4'b1110;
      junction(5'd7, 2'd1);
      junction(5'd30, 2'd2);
      tick(3);
      n_cmp++; if (mif.mode !== 5'd30) begin n_err++; $display("FAIL stop_sticky: got %0d expected 30", mif.mode); end
      start = 1'b1;
      tick(1);
      start = 1'b0;
      n_cmp++; if (mif.mode !== 5'd0) begin n_err++; $display("FAIL stop_clear: got %0d expected 0", mif.mode); end
      n_cmp++; if (mif.junction_cnt !== 2'd2) begin n_err++; $display("FAIL idle_jcnt_kept: got %0d expected 2", mif.junction_cnt); end
      start = 1'b1;
      tick(1);
      start = 1'b0;
      n_cmp++; if (mif.mode !== 5'd1) begin n_err++; $display("FAIL restart: got %0d expected 1", mif.mode); end
      n_cmp++; if (mif.junction_cnt !== 2'd0) begin n_err++; $display("FAIL restart_jcnt: got %0d expected 0", mif.junction_cnt); end
   endtask

   task automatic test_route_end;
      go_straight;
      route = 4'b0000;
      junction(5'd5, 2'd1);
      junction(5'd5, 2'd2);
      junction(5'd30, 2'd2);
   endtask

   task automatic test_lost;
      go_straight;
      sensor = 3'b000;
      tick(5);
      sensor = 3'b010;
      tick(5);
      n_cmp++; if (mif.mode !== 5'd3) begin n_err++; $display("FAIL lost_recover: got %0d expected 3", mif.mode); end
      sensor = 3'b000;
      tick(7);
      n_cmp++; if (mif.mode !== 5'd3) begin n_err++; $display("FAIL lost_pre: got %0d expected 3", mif.mode); end
      tick(1);
      n_cmp++; if (mif.mode !== 5'd31) begin n_err++; $display("FAIL lost_error: got %0d expected 31", mif.mode); end
      n_cmp++; if (mif.fault !== 1'b1) begin n_err++; $display("FAIL lost_fault: got %0d expected 1", mif.fault); end
      tick(3);
      n_cmp++; if (mif.fault !== 1'b1) begin n_err++; $display("FAIL error_sticky: got %0d expected 1", mif.fault); end
      start = 1'b1;
      tick(1);
      start = 1'b0;
      n_cmp++; if (mif.mode !== 5'd0) begin n_err++; $display("FAIL error_clear: got %0d expected 0", mif.mode); end
      n_cmp++; if (mif.fault !== 1'b0) begin n_err++; $display("FAIL error_clear_fault: got %0d expected 0", mif.fault); end
   endtask

   task automatic test_timeout;
      go_straight;
      route = 4'b0101;
      sensor = 3'b111;
      tick(3);
      n_cmp++; if (mif.mode !== 5'd4) begin n_err++; $display("FAIL to_choose: got %0d expected 4", mif.mode); end
      sensor = 3'b100;
      tick(1);
      n_cmp++; if (mif.mode !== 5'd6) begin n_err++; $display("FAIL to_turn: got %0d expected 6", mif.mode); end
      tick(19);
      n_cmp++; if (mif.mode !== 5'd6) begin n_err++; $display("FAIL to_pre: got %0d expected 6", mif.mode); end
      tick(1);
      n_cmp++; if (mif.mode !== 5'd31) begin n_err++; $display("FAIL to_error: got %0d expected 31", mif.mode); end
      n_cmp++; if (mif.fault !== 1'b1) begin n_err++; $display("FAIL to_fault: got %0d expected 1", mif.fault); end
   endtask

   task automatic test_async_reset;
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (mif.mode !== 5'd0) begin n_err++; $display("FAIL areset_err_mode: got %0d expected 0", mif.mode); end
      n_cmp++; if (mif.fault !== 1'b0) begin n_err++; $display("FAIL areset_err_fault: got %0d expected 0", mif.fault); end
      n_cmp++; if (mif.junction_cnt !== 2'd0) begin n_err++; $display("FAIL areset_err_jcnt: got %0d expected 0", mif.junction_cnt); end
      go_straight;
      route = 4'b0101;
      sensor = 3'b111;
      tick(3);
      sensor = 3'b100;
      tick(3);
      n_cmp++; if (mif.mode !== 5'd6) begin n_err++; $display("FAIL areset_turn_pre: got %0d expected 6", mif.mode); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (mif.mode !== 5'd0) begin n_err++; $display("FAIL areset_turn_mode: got %0d expected 0", mif.mode); end
      n_cmp++; if (mif.junction_cnt !== 2'd0) begin n_err++; $display("FAIL areset_turn_jcnt: got %0d expected 0", mif.junction_cnt); end
      tick(1);
      rst_n = 1'b1;
      sensor = 3'b010;
      tick(5);
      n_cmp++; if (mif.mode !== 5'd0) begin n_err++; $display("FAIL areset_no_resume: got %0d expected 0", mif.mode); end
   endtask
`endif

   initial begin
      test_reset;
`ifdef SENSOR_DEBOUNCE_EN
      test_debounce;
`else
      test_turn_left;
      test_two_junctions;
      test_route_end;
      test_lost;
      test_timeout;
      test_async_reset;
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
